// File: rtl/obi_rr_arbiter_if.sv
// Bundle for the two-master / one-slave OBI arbiter.
// The slave modport is the arbiter side; the master modport drives requesters and the shared slave.
interface obi_rr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic                  m0_req_i,    m1_req_i;
  logic                  m0_we_i,     m1_we_i;
  logic [BeWidth-1:0]    m0_be_i,     m1_be_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i,   m1_addr_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i,  m1_wdata_i;
  logic                  m0_gnt_o,    m1_gnt_o;
  logic                  m0_rvalid_o, m1_rvalid_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o,  m1_rdata_o;

  logic                  s_req_o;
  logic                  s_we_o;
  logic [BeWidth-1:0]    s_be_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic [DATA_WIDTH-1:0] s_wdata_o;
  logic                  s_gnt_i;
  logic                  s_rvalid_i;
  logic [DATA_WIDTH-1:0] s_rdata_i;

  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_be_i, m1_be_i,
           m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
           s_gnt_i, s_rvalid_i, s_rdata_i,
    output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
           s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
  );

  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_be_i, m1_be_i,
           m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
           s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
           s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
  );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: two masters share one slave port, with an in-order
// ID FIFO steering responses back to the issuing master.
module obi_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 2,
  localparam int unsigned CntW      = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  obi_rr_arbiter_if.slave   bus,
  output logic [CntW-1:0]   outst_o,
  output logic              err_o
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(MAX_OUTST - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTST);

  logic            prio_q, prio_d;
  logic            lock_q, lock_d;
  logic            lock_id_q, lock_id_d;
  logic            id_mem_q [MAX_OUTST];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic winner, win_req, fifo_full, fifo_empty, s_req, push, pop, head_id;

  // Winner selection; a held (locked) request keeps the slave-side request stable.
  always_comb begin
    winner = 1'b0;
    if (lock_q) begin
      winner = lock_id_q;
    end else if (bus.m0_req_i && bus.m1_req_i) begin
      winner = prio_q;
    end else if (bus.m1_req_i) begin
      winner = 1'b1;
    end
    win_req    = winner ? bus.m1_req_i : bus.m0_req_i;
    fifo_full  = (cnt_q == CntFull);
    fifo_empty = (cnt_q == '0);
    // Gating with rst_ni forces handshake outputs low while reset is held.
    s_req      = win_req && !fifo_full && rst_ni;
    push       = s_req && bus.s_gnt_i;
    pop        = bus.s_rvalid_i && !fifo_empty && rst_ni;
    head_id    = id_mem_q[rd_ptr_q];
  end

  assign bus.s_req_o     = s_req;
  assign bus.s_we_o      = winner ? bus.m1_we_i    : bus.m0_we_i;
  assign bus.s_be_o      = winner ? bus.m1_be_i    : bus.m0_be_i;
  assign bus.s_addr_o    = winner ? bus.m1_addr_i  : bus.m0_addr_i;
  assign bus.s_wdata_o   = winner ? bus.m1_wdata_i : bus.m0_wdata_i;
  assign bus.m0_gnt_o    = push && !winner;
  assign bus.m1_gnt_o    = push && winner;
  assign bus.m0_rvalid_o = pop && !head_id;
  assign bus.m1_rvalid_o = pop && head_id;
  assign bus.m0_rdata_o  = bus.s_rdata_i;
  assign bus.m1_rdata_o  = bus.s_rdata_i;
  assign outst_o         = cnt_q;
  assign err_o           = err_q;

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (push) begin
      lock_d   = 1'b0;
      prio_d   = ~winner;
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (s_req) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
    end

    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end

    // A response with nothing outstanding is a protocol error, even if a push lands now.
    if (bus.s_rvalid_i && fifo_empty && rst_ni) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        id_mem_q[i] <= 1'b0;
      end
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      if (push) begin
        id_mem_q[wr_ptr_q] <= winner;
      end
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: grant expectations feed a scoreboard of
// issuing masters that is popped and checked whenever a response is driven.
module tb_obi_rr_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] outst;
  logic       err;

  int n_cmp;
  int n_err;
  bit sb_q [$];

  obi_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  obi_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .outst_o (outst),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m0_req_i   = 1'b0;
    bus.m1_req_i   = 1'b0;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b0;
  endtask

  task automatic grant_chk(input string tag, input bit exp_m);
    chk({tag, "_gnt0"}, 64'(bus.m0_gnt_o), 64'(exp_m == 1'b0));
    chk({tag, "_gnt1"}, 64'(bus.m1_gnt_o), 64'(exp_m == 1'b1));
    sb_q.push_back(exp_m);
  endtask

  task automatic resp_chk(input string tag, input logic [31:0] d);
    bit exp_m;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      exp_m = sb_q.pop_front();
      chk({tag, "_rv0"}, 64'(bus.m0_rvalid_o), 64'(exp_m == 1'b0));
      chk({tag, "_rv1"}, 64'(bus.m1_rvalid_o), 64'(exp_m == 1'b1));
      chk({tag, "_rd0"}, 64'(bus.m0_rdata_o), 64'(d));
      chk({tag, "_rd1"}, 64'(bus.m1_rdata_o), 64'(d));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    idle();
    bus.m0_we_i = 1'b0;  bus.m1_we_i = 1'b1;
    bus.m0_be_i = 4'hF;  bus.m1_be_i = 4'h3;
    bus.m0_addr_i = 32'h0000_1000;  bus.m1_addr_i = 32'h0000_2000;
    bus.m0_wdata_i = 32'h1111_0000; bus.m1_wdata_i = 32'h2222_0000;
    bus.s_rdata_i = '0;
    #2 rst_n = 1'b0;
    next();
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sreq", 64'(bus.s_req_o), 64'd0);
    next();
    rst_n = 1'b1;

    // 1: single master read
    bus.m0_req_i = 1'b1; bus.s_gnt_i = 1'b1;
    #1;
    chk("t1_sreq", 64'(bus.s_req_o), 64'd1);
    chk("t1_addr", 64'(bus.s_addr_o), 64'h1000);
    chk("t1_we", 64'(bus.s_we_o), 64'd0);
    grant_chk("t1", 1'b0);
    next();
    idle();
    chk("t1_outst1", 64'(outst), 64'd1);
    next();
    chk("t1_rv1_idle", 64'(bus.m1_rvalid_o), 64'd0);
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'hDEAD_BEEF;
    #1;
    resp_chk("t1_resp", 32'hDEAD_BEEF);
    next();
    idle();
    chk("t1_outst0", 64'(outst), 64'd0);

    // 2: contention after reset, alternating grants with same-cycle push/pop
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.m0_req_i = 1'b1; bus.m1_req_i = 1'b1; bus.s_gnt_i = 1'b1;
      bus.s_rvalid_i = (i > 0); bus.s_rdata_i = 32'h100 + 32'(i);
      #1;
      chk("t2_addr", 64'(bus.s_addr_o), (i % 2 == 1) ? 64'h2000 : 64'h1000);
      if (i > 0) resp_chk("t2_resp", 32'h100 + 32'(i));
      grant_chk("t2", bit'(i % 2));
      next();
      chk("t2_outst", 64'(outst), 64'd1);
    end
    idle();
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'h55;
    #1;
    resp_chk("t2_drain", 32'h55);
    next();
    idle();
    chk("t2_outst0", 64'(outst), 64'd0);

    // 3: lock on m1 while m0 (which now has priority) joins
    bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h0000_3000;
    #1;
    chk("t3_sreq", 64'(bus.s_req_o), 64'd1);
    chk("t3_addr0", 64'(bus.s_addr_o), 64'h3000);
    next();
    bus.m0_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_addr_lock", 64'(bus.s_addr_o), 64'h3000);
      chk("t3_gnt0_lock", 64'(bus.m0_gnt_o), 64'd0);
      next();
    end
    bus.s_gnt_i = 1'b1;
    #1;
    grant_chk("t3_m1", 1'b1);
    next();
    bus.m1_req_i = 1'b0;
    #1;
    chk("t3_addr_m0", 64'(bus.s_addr_o), 64'h1000);
    grant_chk("t3_m0", 1'b0);
    next();

    // 4: FIFO full blocks requests until a response frees a slot
    bus.m1_req_i = 1'b1;
    #1;
    chk("t4_outst2", 64'(outst), 64'd2);
    chk("t4_sreq_full", 64'(bus.s_req_o), 64'd0);
    chk("t4_gnt0_full", 64'(bus.m0_gnt_o), 64'd0);
    chk("t4_gnt1_full", 64'(bus.m1_gnt_o), 64'd0);
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'h11;
    #1;
    resp_chk("t4_resp", 32'h11);
    chk("t4_sreq_pop", 64'(bus.s_req_o), 64'd0);
    next();
    bus.s_rvalid_i = 1'b0;
    #1;
    chk("t4_outst1", 64'(outst), 64'd1);
    chk("t4_sreq_again", 64'(bus.s_req_o), 64'd1);
    grant_chk("t4_m1", 1'b1);
    next();
    idle();

    // 5: in-order response routing, then simultaneous grant and response
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'hA;
    #1;
    resp_chk("t5_a", 32'hA);
    next();
    bus.s_rdata_i = 32'hB;
    #1;
    resp_chk("t5_b", 32'hB);
    next();
    idle();
    chk("t5_outst0", 64'(outst), 64'd0);
    bus.m0_req_i = 1'b1; bus.s_gnt_i = 1'b1;
    #1;
    grant_chk("t5_g1", 1'b0);
    next();
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'hC;
    #1;
    resp_chk("t5_c", 32'hC);
    grant_chk("t5_g2", 1'b0);
    next();
    idle();
    chk("t5_outst_keep", 64'(outst), 64'd1);
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'hD;
    #1;
    resp_chk("t5_d", 32'hD);
    next();
    idle();

    // 6: spurious response sets sticky error; reset mid-lock clears everything
    bus.s_rvalid_i = 1'b1;
    #1;
    chk("t6_rv0_spur", 64'(bus.m0_rvalid_o), 64'd0);
    chk("t6_rv1_spur", 64'(bus.m1_rvalid_o), 64'd0);
    next();
    idle();
    chk("t6_err", 64'(err), 64'd1);
    next();
    next();
    chk("t6_err_sticky", 64'(err), 64'd1);
    bus.m1_req_i = 1'b1;
    next();
    bus.m0_req_i = 1'b1; bus.s_gnt_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sreq", 64'(bus.s_req_o), 64'd0);
    chk("t6_rst_gnt0", 64'(bus.m0_gnt_o), 64'd0);
    chk("t6_rst_gnt1", 64'(bus.m1_gnt_o), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_outst", 64'(outst), 64'd0);
    next();
    rst_n = 1'b1;
    #1;
    grant_chk("t6_prio_m0", 1'b0);
    next();
    idle();
    bus.s_rvalid_i = 1'b1; bus.s_rdata_i = 32'hE;
    #1;
    resp_chk("t6_resp", 32'hE);
    next();
    idle();
    chk("end_outst0", 64'(outst), 64'd0);
    chk("end_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
Two-master, one-slave OBI arbiter that shares the bridge's HEEP-facing OBI request port between two requesters, for example the HEEP bus bridge and a host-side debug/DMA requester.
- Selects one request per cycle using round-robin priority.
- Forwards the request to the slave port and tracks outstanding transactions in order.
- Steers each response (rvalid/rdata) back to the master that issued it.
- Sits between the requesters and the bridge2xheep OBI interface, in the heep_clk domain.

Parameters:
- ADDR_WIDTH, 32, OBI address width.
- DATA_WIDTH, 32, OBI wdata/rdata width; byte enable width is DATA_WIDTH/8.
- MAX_OUTST, 2, maximum accepted-but-unanswered transactions (power of 2, >=1).

Ports:
- clk_i  in  1  Clock, heep_clk domain.
- rst_ni  in  1  Reset, asynchronous, active-low.
- m0_req_i, m1_req_i  in  1  Master request.
- m0_we_i, m1_we_i  in  1  Write enable.
- m0_be_i, m1_be_i  in  DATA_WIDTH/8  Byte enables.
- m0_addr_i, m1_addr_i  in  ADDR_WIDTH  Address.
- m0_wdata_i, m1_wdata_i  in  DATA_WIDTH  Write data.
- m0_gnt_o, m1_gnt_o  out  1  Grant to master.
- m0_rvalid_o, m1_rvalid_o  out  1  Response valid to master.
- m0_rdata_o, m1_rdata_o  out  DATA_WIDTH  Response data (shared s_rdata_i).
- s_req_o  out  1  Slave request.
- s_we_o  out  1  Slave write enable.
- s_be_o  out  DATA_WIDTH/8  Slave byte enables.
- s_addr_o  out  ADDR_WIDTH  Slave address.
- s_wdata_o  out  DATA_WIDTH  Slave write data.
- s_gnt_i  in  1  Slave grant.
- s_rvalid_i  in  1  Slave response valid.
- s_rdata_i  in  DATA_WIDTH  Slave response data.
- outst_o  out  $clog2(MAX_OUTST+1)  Current outstanding count.
- err_o  out  1  Sticky protocol error flag.

Behaviour:
Reset values:
- Priority pointer = m0.
- Lock = 0; ID FIFO empty; outst_o = 0; err_o = 0.
- All gnt/rvalid/s_req outputs = 0.

Arbitration:
- Combinational, zero-cycle request path.
- If unlocked: winner = the sole requester, or, when both request, the one indicated by the priority pointer.
- s_req_o = (any req) & !fifo_full.
- s_we/be/addr/wdata are muxed from the winner.

Lock:
- If s_req_o=1 and s_gnt_i=0, register lock=1 and hold the winner ID. OBI requires the request to stay stable until granted.
- While locked, the held ID selects the master. The other master's request is ignored.
- Lock clears on the handshake cycle.

Grant:
- mX_gnt_o = s_gnt_i & s_req_o & (winner==X); the other master's gnt = 0.
- On handshake, the pointer moves to the non-winning master.

Outstanding tracking:
- Circular ID FIFO, depth MAX_OUTST.
- Handshake pushes the winner ID; s_rvalid_i pops.
- Push and pop in the same cycle: count unchanged, both pointers advance, pointers wrap modulo MAX_OUTST.
- FIFO full: s_req_o forced 0, no grant. A response on that same cycle pops; the new request is not presented until the next cycle.

Response routing:
- mX_rvalid_o = s_rvalid_i & !fifo_empty & (head ID == X).
- rdata is broadcast to both masters unchanged.
- Response delivery is combinational, zero latency.

Errors:
- s_rvalid_i while the FIFO is empty, without a same-cycle push: err_o set sticky until reset; no rvalid is forwarded.
- Same-cycle handshake and rvalid with an empty FIFO is also an error; the pushed ID is not popped.

Reset:
- Asynchronous reset mid-transaction discards the lock, FIFO and pointer immediately. Outputs go to their reset values in the same cycle.

Test Plan:
1. Single master, no contention: m0 read of addr 0x0000_1000 with s_gnt_i=1 in cycle 0 and s_rvalid_i=1, s_rdata_i=0xDEADBEEF in cycle 2 -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 with rdata 0xDEADBEEF in cycle 2; m1 outputs stay 0; outst_o goes 1 then 0.
2. Contention after reset with s_gnt_i tied 1: both masters request continuously -> grants alternate m0, m1, m0, m1; s_addr_o follows the winner each cycle.
3. Lock: m1 requests alone with s_gnt_i=0 for 3 cycles while m0 raises req in cycle 1 -> s_addr_o stays m1's address; m0_gnt_o=0; at s_gnt_i=1 m1_gnt_o=1; m0 is served next.
4. Full: MAX_OUTST=2, two grants without responses -> outst_o=2; s_req_o=0 despite requests. One s_rvalid_i returns to the first granter and outst_o=1; s_req_o reasserts the following cycle.
5. Ordering: grant m0 then m1, then two rvalids with rdata 0xA then 0xB -> m0 gets 0xA, m1 gets 0xB. A same-cycle grant+rvalid at outst_o=1 keeps outst_o=1.
6. Errors and reset: s_rvalid_i with FIFO empty -> err_o=1 persists, no mX_rvalid. Assert rst_ni low mid-lock -> all outputs 0 immediately; after release m0 has priority.
